// File: rtl/checkers_engine.sv
// Checkers move engine: owns the board, evaluates legal moves for a selected piece and
// applies steps and jumps with multi-jump continuation, promotion and win detection.
module checkers_engine #(
    parameter int BOARD_DIM = 8,
    parameter int INIT_ROWS = 3,
    localparam int CW = $clog2(BOARD_DIM),
    localparam int LW = 2 * CW,
    localparam int SW = 2 + LW,
    localparam int NC = BOARD_DIM * BOARD_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_valid,
    input  logic [LW-1:0]     sel_loc,
    input  logic              ld_en,
    input  logic [LW-1:0]     ld_loc,
    input  logic [2:0]        ld_cell,
    output logic [4*SW-1:0]   legal_move,
    output logic [3*NC-1:0]   serialized_board,
    output logic              turn,
    output logic [LW-1:0]     red_count,
    output logic [LW-1:0]     white_count,
    output logic              busy,
    output logic              reject,
    output logic              game_over,
    output logic              winner
);

    localparam int IW = $clog2(NC);
    localparam logic [LW-1:0] INIT_COUNT = LW'(INIT_ROWS * BOARD_DIM / 2);

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        WAIT_DEST,
        APPLY,
        EVAL_CONT,
        SWITCH,
        DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       cells_q [NC];
    logic [LW-1:0]    src_q;
    logic [LW-1:0]    dst_q;
    logic             mvJump_q;
    logic             cont_q;
    logic             turn_q;
    logic             reject_q;
    logic             gameOver_q;
    logic             winner_q;
    logic [4*SW-1:0]  legal_q;
    logic [LW-1:0]    redCnt_q;
    logic [LW-1:0]    whiteCnt_q;

    logic [2:0]       srcCell;
    logic [4*SW-1:0]  evalAll_d;
    logic [4*SW-1:0]  evalJump_d;
    logic             anyAll;
    logic             anyJump;
    logic             destHit;
    logic             destJump;
    logic [CW-1:0]    srcX;
    logic [CW-1:0]    srcY;
    logic [CW-1:0]    dstX;
    logic [CW-1:0]    dstY;
    logic [CW-1:0]    midX;
    logic [CW-1:0]    midY;
    logic             promote;
    logic             ldOnBoard;
    logic [2:0]       ldOld;
    logic [LW-1:0]    redLd_d;
    logic [LW-1:0]    whiteLd_d;
    logic [2:0]       selCell;
    logic             selOwn;

    // Cell {x,y} lives at x*BOARD_DIM+y, which is the plain concatenation for power-of-two boards.
    function automatic logic [IW-1:0] cellIdx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return IW'(int'(x) * BOARD_DIM + int'(y));
    endfunction

    function automatic logic onBoard(input logic [LW-1:0] loc);
        return (int'(loc[LW-1:CW]) < BOARD_DIM) && (int'(loc[CW-1:0]) < BOARD_DIM);
    endfunction

    function automatic logic [2:0] initCell(input int x, input int y);
        if ((x + y) % 2 == 0) return 3'b000;
        if (y < INIT_ROWS) return 3'b110;
        if (y >= BOARD_DIM - INIT_ROWS) return 3'b100;
        return 3'b000;
    endfunction

    assign srcX = src_q[LW-1:CW];
    assign srcY = src_q[CW-1:0];
    assign dstX = dst_q[LW-1:CW];
    assign dstY = dst_q[CW-1:0];
    assign srcCell = cells_q[cellIdx(srcX, srcY)];

    // Slots 0/1 move towards +y (red men), 2/3 towards -y (white men); kings use all four.
    always_comb begin : evalComb
        logic [CW-1:0] nx, ny, jx, jy;
        logic          xNeg, yPos, nearIn, farIn, allowed, stepOk, jumpOk;
        logic [2:0]    nearCell, farCell;
        nx = '0; ny = '0; jx = '0; jy = '0;
        xNeg = 1'b0; yPos = 1'b0; nearIn = 1'b0; farIn = 1'b0;
        allowed = 1'b0; stepOk = 1'b0; jumpOk = 1'b0;
        nearCell = 3'b000; farCell = 3'b000;
        evalAll_d = '0;
        evalJump_d = '0;
        anyAll = 1'b0;
        anyJump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            xNeg = (k == 0) || (k == 2);
            yPos = (k < 2);
            nearIn = (xNeg ? (int'(srcX) >= 1) : (int'(srcX) <= BOARD_DIM - 2)) &&
                     (yPos ? (int'(srcY) <= BOARD_DIM - 2) : (int'(srcY) >= 1));
            farIn  = (xNeg ? (int'(srcX) >= 2) : (int'(srcX) <= BOARD_DIM - 3)) &&
                     (yPos ? (int'(srcY) <= BOARD_DIM - 3) : (int'(srcY) >= 2));
            nx = xNeg ? srcX - CW'(1) : srcX + CW'(1);
            ny = yPos ? srcY + CW'(1) : srcY - CW'(1);
            jx = xNeg ? srcX - CW'(2) : srcX + CW'(2);
            jy = yPos ? srcY + CW'(2) : srcY - CW'(2);
            nearCell = nearIn ? cells_q[cellIdx(nx, ny)] : 3'b000;
            farCell = farIn ? cells_q[cellIdx(jx, jy)] : 3'b000;
            allowed = srcCell[2] && (srcCell[0] || (srcCell[1] ? yPos : !yPos));
            stepOk = allowed && nearIn && !nearCell[2];
            jumpOk = allowed && farIn && nearCell[2] && (nearCell[1] != srcCell[1]) && !farCell[2];
            if (jumpOk) begin
                evalAll_d[k*SW +: SW] = {2'b11, jx, jy};
                evalJump_d[k*SW +: SW] = {2'b11, jx, jy};
            end else if (stepOk) begin
                evalAll_d[k*SW +: SW] = {2'b10, nx, ny};
            end
            anyAll = anyAll | jumpOk | stepOk;
            anyJump = anyJump | jumpOk;
        end
    end

    always_comb begin : matchComb
        destHit = 1'b0;
        destJump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (legal_q[k*SW + SW - 1] && (legal_q[k*SW +: LW] == sel_loc)) begin
                destHit = 1'b1;
                destJump = legal_q[k*SW + LW];
            end
        end
    end

    always_comb begin : applyComb
        midX = CW'(({1'b0, srcX} + {1'b0, dstX}) >> 1);
        midY = CW'(({1'b0, srcY} + {1'b0, dstY}) >> 1);
        promote = !srcCell[0] && (srcCell[1] ? (int'(dstY) == BOARD_DIM - 1) : (dstY == '0));
    end

    // A debug load adjusts the counts by the difference between the old and new cell.
    always_comb begin : loadComb
        ldOnBoard = onBoard(ld_loc);
        ldOld = ldOnBoard ? cells_q[cellIdx(ld_loc[LW-1:CW], ld_loc[CW-1:0])] : 3'b000;
        redLd_d = redCnt_q - LW'(ldOld[2] & ldOld[1]) + LW'(ld_cell[2] & ld_cell[1]);
        whiteLd_d = whiteCnt_q - LW'(ldOld[2] & !ldOld[1]) + LW'(ld_cell[2] & !ld_cell[1]);
        selCell = onBoard(sel_loc) ? cells_q[cellIdx(sel_loc[LW-1:CW], sel_loc[CW-1:0])] : 3'b000;
        selOwn = selCell[2] && (selCell[1] == turn_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            turn_q     <= 1'b1;
            legal_q    <= '0;
            reject_q   <= 1'b0;
            gameOver_q <= 1'b0;
            winner_q   <= 1'b0;
            cont_q     <= 1'b0;
            mvJump_q   <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            redCnt_q   <= INIT_COUNT;
            whiteCnt_q <= INIT_COUNT;
            for (int x = 0; x < BOARD_DIM; x++) begin
                for (int y = 0; y < BOARD_DIM; y++) begin
                    cells_q[cellIdx(CW'(x), CW'(y))] <= initCell(x, y);
                end
            end
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_en) begin
                        if (ldOnBoard) begin
                            cells_q[cellIdx(ld_loc[LW-1:CW], ld_loc[CW-1:0])] <= ld_cell;
                            redCnt_q   <= redLd_d;
                            whiteCnt_q <= whiteLd_d;
                        end
                    end else if (sel_valid) begin
                        if (selOwn) begin
                            src_q   <= sel_loc;
                            state_q <= EVAL;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                EVAL: begin
                    legal_q <= evalAll_d;
                    if (anyAll) begin
                        state_q <= WAIT_DEST;
                    end else begin
                        reject_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                WAIT_DEST: begin
                    if (sel_valid) begin
                        if ((sel_loc == src_q) && !cont_q) begin
                            legal_q <= '0;
                            state_q <= IDLE;
                        end else if (destHit) begin
                            dst_q    <= sel_loc;
                            mvJump_q <= destJump;
                            state_q  <= APPLY;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    cells_q[cellIdx(dstX, dstY)] <= promote ? (srcCell | 3'b001) : srcCell;
                    cells_q[cellIdx(srcX, srcY)] <= 3'b000;
                    if (mvJump_q) begin
                        cells_q[cellIdx(midX, midY)] <= 3'b000;
                        if (turn_q) whiteCnt_q <= whiteCnt_q - LW'(1);
                        else        redCnt_q   <= redCnt_q - LW'(1);
                    end
                    // A capture that crowns the piece ends the turn; otherwise look for another capture.
                    if (mvJump_q && !promote) begin
                        src_q   <= dst_q;
                        state_q <= EVAL_CONT;
                    end else begin
                        state_q <= SWITCH;
                    end
                end
                EVAL_CONT: begin
                    legal_q <= evalJump_d;
                    if (anyJump) begin
                        cont_q  <= 1'b1;
                        state_q <= WAIT_DEST;
                    end else begin
                        state_q <= SWITCH;
                    end
                end
                SWITCH: begin
                    legal_q <= '0;
                    cont_q  <= 1'b0;
                    if ((turn_q ? whiteCnt_q : redCnt_q) == '0) begin
                        gameOver_q <= 1'b1;
                        winner_q   <= turn_q;
                        state_q    <= DONE;
                    end else begin
                        turn_q  <= !turn_q;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    if (sel_valid) reject_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin : serializeComb
        serialized_board = '0;
        for (int i = 0; i < NC; i++) begin
            serialized_board[3*i +: 3] = cells_q[i];
        end
    end

    assign legal_move  = legal_q;
    assign turn        = turn_q;
    assign red_count   = redCnt_q;
    assign white_count = whiteCnt_q;
    assign busy        = (state_q != IDLE) && (state_q != WAIT_DEST);
    assign reject      = reject_q;
    assign game_over   = gameOver_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_checkers_engine.sv
// Directed bench for checkers_engine on an 8x8 board: a selection vector table plus
// hand-written sequences for captures, promotion, game end and reset.
module tb_checkers_engine;

    localparam int DIM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel_valid;
    logic [5:0]    sel_loc;
    logic          ld_en;
    logic [5:0]    ld_loc;
    logic [2:0]    ld_cell;
    logic [31:0]   legal_move;
    logic [191:0]  serialized_board;
    logic          turn;
    logic [5:0]    red_count;
    logic [5:0]    white_count;
    logic          busy;
    logic          reject;
    logic          game_over;
    logic          winner;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0]  x;
        logic [2:0]  y;
        logic        selRej;
        logic        evalRej;
        logic [31:0] legal;
    } vec_t;

    vec_t vecs[6];

    checkers_engine #(.BOARD_DIM(DIM), .INIT_ROWS(3)) dut (
        .clk(clk),
        .rst(rst),
        .sel_valid(sel_valid),
        .sel_loc(sel_loc),
        .ld_en(ld_en),
        .ld_loc(ld_loc),
        .ld_cell(ld_cell),
        .legal_move(legal_move),
        .serialized_board(serialized_board),
        .turn(turn),
        .red_count(red_count),
        .white_count(white_count),
        .busy(busy),
        .reject(reject),
        .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] slotV(input logic j, input int x, input int y);
        logic [2:0] xs;
        logic [2:0] ys;
        xs = x[2:0];
        ys = y[2:0];
        return {1'b1, j, xs, ys};
    endfunction

    function automatic logic [2:0] cellAt(input int x, input int y);
        return serialized_board[3*(x*DIM + y) +: 3];
    endfunction

    function automatic logic [191:0] resetBoard();
        logic [191:0] b;
        b = '0;
        for (int x = 0; x < DIM; x++) begin
            for (int y = 0; y < DIM; y++) begin
                if ((x + y) % 2 == 1 && y < 3) b[3*(x*DIM + y) +: 3] = 3'b110;
                if ((x + y) % 2 == 1 && y >= 5) b[3*(x*DIM + y) +: 3] = 3'b100;
            end
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input int x, input int y);
        sel_valid = 1'b1;
        sel_loc = {x[2:0], y[2:0]};
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic loadCell(input int x, input int y, input logic [2:0] c);
        ld_en = 1'b1;
        ld_loc = {x[2:0], y[2:0]};
        ld_cell = c;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic waitNotBusy(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: busy=%0b, expected 0", name, busy);
        end
    endtask

    task automatic waitGameOver(input string name);
        int n;
        n = 0;
        while (!game_over && n < 20) begin
            tick();
            n++;
        end
        if (!game_over) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: game_over=%0b, expected 1", name, game_over);
        end
    endtask

    initial begin
        rst = 1'b0;
        sel_valid = 1'b0;
        sel_loc = '0;
        ld_en = 1'b0;
        ld_loc = '0;
        ld_cell = '0;

        vecs[0] = '{x: 3'd1, y: 3'd2, selRej: 1'b0, evalRej: 1'b0, legal: {16'h0, slotV(0, 2, 3), slotV(0, 0, 3)}};
        vecs[1] = '{x: 3'd7, y: 3'd2, selRej: 1'b0, evalRej: 1'b0, legal: {24'h0, slotV(0, 6, 3)}};
        vecs[2] = '{x: 3'd0, y: 3'd1, selRej: 1'b0, evalRej: 1'b1, legal: 32'h0};
        vecs[3] = '{x: 3'd0, y: 3'd0, selRej: 1'b1, evalRej: 1'b0, legal: 32'h0};
        vecs[4] = '{x: 3'd0, y: 3'd5, selRej: 1'b1, evalRej: 1'b0, legal: 32'h0};
        vecs[5] = '{x: 3'd3, y: 3'd2, selRej: 1'b0, evalRej: 1'b0, legal: {16'h0, slotV(0, 4, 3), slotV(0, 2, 3)}};

        // Reset state
        doReset();
        checkOutput("reset red_count", red_count, 12);
        checkOutput("reset white_count", white_count, 12);
        checkOutput("reset turn", turn, 1);
        checkOutput("reset cell(1,0)", cellAt(1, 0), 3'b110);
        checkOutput("reset cell(0,0)", cellAt(0, 0), 3'b000);
        checkOutput("reset cell(0,7)", cellAt(0, 7), 3'b100);
        checkOutput("reset board", serialized_board, resetBoard());
        checkOutput("reset busy", busy, 0);
        checkOutput("reset legal", legal_move, 0);
        checkOutput("reset game_over", game_over, 0);

        // Selection table on the opening position
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(vecs[i].x, vecs[i].y);
            checkOutput($sformatf("vec%0d sel reject", i), reject, vecs[i].selRej);
            if (!vecs[i].selRej) begin
                tick();
                checkOutput($sformatf("vec%0d eval reject", i), reject, vecs[i].evalRej);
                checkOutput($sformatf("vec%0d legal", i), legal_move, vecs[i].legal);
                if (!vecs[i].evalRej) begin
                    checkOutput($sformatf("vec%0d wait busy", i), busy, 0);
                    applyStimulus(vecs[i].x, vecs[i].y);
                    checkOutput($sformatf("vec%0d deselect reject", i), reject, 0);
                    checkOutput($sformatf("vec%0d deselect legal", i), legal_move, 0);
                end
            end
        end

        // Simple step (1,2)->(2,3)
        doReset();
        applyStimulus(1, 2);
        tick();
        applyStimulus(2, 3);
        waitNotBusy("step");
        checkOutput("step cell(2,3)", cellAt(2, 3), 3'b110);
        checkOutput("step cell(1,2)", cellAt(1, 2), 3'b000);
        checkOutput("step turn", turn, 0);
        checkOutput("step legal", legal_move, 0);

        // Load and select in the same IDLE cycle: load wins, selection dropped silently
        doReset();
        sel_valid = 1'b1;
        sel_loc = {3'd1, 3'd2};
        ld_en = 1'b1;
        ld_loc = {3'd0, 3'd0};
        ld_cell = 3'b110;
        tick();
        sel_valid = 1'b0;
        ld_en = 1'b0;
        checkOutput("ldsel reject", reject, 0);
        checkOutput("ldsel cell(0,0)", cellAt(0, 0), 3'b110);
        checkOutput("ldsel red_count", red_count, 13);
        tick();
        checkOutput("ldsel legal", legal_move, 0);
        checkOutput("ldsel busy", busy, 0);

        // Double capture (2,2)->(4,4)->(6,6)
        doReset();
        loadCell(2, 2, 3'b110);
        loadCell(3, 3, 3'b100);
        loadCell(5, 5, 3'b100);
        loadCell(4, 4, 3'b000);
        loadCell(6, 6, 3'b000);
        tick();
        checkOutput("dbl red_count", red_count, 13);
        checkOutput("dbl white_count", white_count, 14);
        applyStimulus(2, 2);
        tick();
        checkOutput("dbl legal", legal_move, {16'h0, slotV(1, 4, 4), slotV(0, 1, 3)});
        applyStimulus(4, 4);
        waitNotBusy("dbl first");
        checkOutput("dbl white after 1", white_count, 13);
        checkOutput("dbl cont legal", legal_move, {16'h0, slotV(1, 6, 6), 8'h0});
        checkOutput("dbl cell(3,3)", cellAt(3, 3), 3'b000);
        checkOutput("dbl turn mid", turn, 1);
        applyStimulus(4, 4);
        checkOutput("dbl deselect reject", reject, 1);
        checkOutput("dbl deselect busy", busy, 0);
        checkOutput("dbl deselect legal", legal_move, {16'h0, slotV(1, 6, 6), 8'h0});
        applyStimulus(6, 6);
        waitNotBusy("dbl second");
        checkOutput("dbl cell(6,6)", cellAt(6, 6), 3'b110);
        checkOutput("dbl cell(5,5)", cellAt(5, 5), 3'b000);
        checkOutput("dbl cell(4,4)", cellAt(4, 4), 3'b000);
        checkOutput("dbl white after 2", white_count, 12);
        checkOutput("dbl turn end", turn, 0);
        checkOutput("dbl legal end", legal_move, 0);

        // Promotion on a step to the far row
        doReset();
        loadCell(1, 6, 3'b110);
        loadCell(0, 7, 3'b000);
        applyStimulus(1, 6);
        tick();
        checkOutput("promo legal", legal_move, {24'h0, slotV(0, 0, 7)});
        applyStimulus(0, 7);
        waitNotBusy("promo");
        checkOutput("promo cell(0,7)", cellAt(0, 7), 3'b111);
        checkOutput("promo cell(1,6)", cellAt(1, 6), 3'b000);
        checkOutput("promo turn", turn, 0);
        checkOutput("promo red_count", red_count, 13);

        // Capturing the last white piece ends the game
        doReset();
        for (int x = 0; x < DIM; x++) begin
            for (int y = 5; y < DIM; y++) begin
                if ((x + y) % 2 == 1) loadCell(x, y, 3'b000);
            end
        end
        loadCell(2, 3, 3'b100);
        checkOutput("end white_count", white_count, 1);
        applyStimulus(1, 2);
        tick();
        applyStimulus(3, 4);
        waitGameOver("end");
        checkOutput("end game_over", game_over, 1);
        checkOutput("end winner", winner, 1);
        checkOutput("end white_count 0", white_count, 0);
        checkOutput("end cell(3,4)", cellAt(3, 4), 3'b110);
        checkOutput("end turn", turn, 1);
        applyStimulus(0, 1);
        checkOutput("end sel reject", reject, 1);
        loadCell(0, 0, 3'b110);
        checkOutput("end load ignored", cellAt(0, 0), 3'b000);

        // Reset out of DONE, then off-slot destination followed by reset mid-move
        doReset();
        checkOutput("rst from done game_over", game_over, 0);
        checkOutput("rst from done winner", winner, 0);
        applyStimulus(1, 2);
        tick();
        applyStimulus(5, 5);
        checkOutput("offslot reject", reject, 1);
        checkOutput("offslot busy", busy, 0);
        checkOutput("offslot legal", legal_move, {16'h0, slotV(0, 2, 3), slotV(0, 0, 3)});
        rst = 1'b0;
        tick();
        checkOutput("midrst reject", reject, 0);
        checkOutput("midrst legal", legal_move, 0);
        checkOutput("midrst turn", turn, 1);
        checkOutput("midrst red_count", red_count, 12);
        checkOutput("midrst white_count", white_count, 12);
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst board", serialized_board, resetBoard());
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/checkers_engine.md
CHECKERS_ENGINE -- requirements
Module: checkers_engine

Interface
REQ-001 Parameter BOARD_DIM, default 8, board edge length; even and at least 4.
REQ-002 Parameter INIT_ROWS, default 3, rows of pieces per side at reset; 2*INIT_ROWS < BOARD_DIM.
REQ-003 Derived CW = clog2(BOARD_DIM) is the coordinate width; a location is {x[CW-1:0], y[CW-1:0]}, with x in the upper bits.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 sel_valid  in  1  one-cycle selection strobe.
REQ-007 sel_loc  in  2*CW  location selected (source piece or destination).
REQ-008 ld_en  in  1  debug cell-load strobe.
REQ-009 ld_loc / ld_cell  in  2*CW / 3  cell to overwrite and the value to write.
REQ-010 legal_move  out  4*(2+2*CW)  four slots of {valid, jump, loc}; slot0 = (-1,+1), slot1 = (+1,+1), slot2 = (-1,-1), slot3 = (+1,-1).
REQ-011 serialized_board  out  3*BOARD_DIM^2  cell at index {x,y} on bits [3i+2:3i].
REQ-012 turn  out  1  side to move; 1 = red.
REQ-013 red_count / white_count  out  2*CW each  pieces remaining per side.
REQ-014 busy  out  1  high in every state except IDLE and WAIT_DEST.
REQ-015 reject  out  1  one-cycle pulse when a selection is refused.
REQ-016 game_over / winner  out  1 / 1  game_over set when a side has no pieces; winner 1 = red.

Function
REQ-017 Cell encoding: [2] occupied, [1] red, [0] king; an empty cell is 3'b000.
REQ-018 The block SHALL implement the states IDLE, EVAL, WAIT_DEST, APPLY, EVAL_CONT, SWITCH and DONE.
REQ-019 IDLE, sel_valid on a cell occupied by a piece of colour turn: latch the location as src and go to EVAL; any other selection pulses reject and stays in IDLE.
REQ-020 EVAL is one cycle and registers legal_move for src:
  - red men use slots 0-1, white men use slots 2-3, kings use all four slots;
  - a step is valid when the target is on the board and empty (jump = 0);
  - a jump is valid when the diagonal neighbour holds an opponent piece and the square beyond is on the board and empty (jump = 1, loc = landing square).
REQ-021 In EVAL, a jump takes precedence over a step in the same slot; when all slots are invalid, pulse reject and return to IDLE.
REQ-022 WAIT_DEST, sel_valid:
  - sel_loc == src with the continuation flag clear: clear legal_move and return to IDLE;
  - sel_loc equals the loc of a valid slot: go to APPLY;
  - any other location: pulse reject and remain in WAIT_DEST.
REQ-023 APPLY is one cycle and performs all of the following together:
  - dest <= src cell;
  - src <= 0;
  - on a jump, the midpoint cell <= 0 and the opponent's count decrements;
  - promotion: red reaching y = BOARD_DIM-1, or white reaching y = 0, sets bit [0].
REQ-024 After APPLY:
  - on a non-promoting jump, go to EVAL_CONT with src = dest;
  - otherwise, go to SWITCH.
REQ-025 EVAL_CONT evaluates jump slots only:
  - if any slot is valid, set the continuation flag and go to WAIT_DEST;
  - otherwise, go to SWITCH.
REQ-026 While the continuation flag is set, deselecting is illegal and pulses reject.
REQ-027 SWITCH:
  - clear legal_move and the continuation flag;
  - if the opponent's count == 0, set game_over and winner = mover, and go to DONE;
  - otherwise toggle turn and go to IDLE.
REQ-028 DONE holds all state and pulses reject on every sel_valid until reset.
REQ-029 ld_en takes effect only in IDLE:
  - write ld_loc <= ld_cell;
  - recompute red_count and white_count by the next IDLE cycle;
  - in other states, ld_en is ignored.
REQ-030 sel_valid and ld_en asserted in the same IDLE cycle: ld_en wins and the selection is dropped without reject.
REQ-031 Coordinate arithmetic SHALL be bounds-checked before any board index is formed; no wrap-around is permitted.

Reset
REQ-032 While rst = 0 on a clock edge, the block SHALL reach this state:
  - state = IDLE, turn = 1;
  - legal_move = 0, reject = 0, busy = 0, game_over = 0, winner = 0, continuation flag = 0.
REQ-033 Reset board layout:
  - red men (3'b110) on rows y < INIT_ROWS where x+y is odd;
  - white men (3'b100) on rows y >= BOARD_DIM-INIT_ROWS where x+y is odd;
  - all other cells 0.
REQ-034 Reset counts: red_count = white_count = INIT_ROWS*BOARD_DIM/2.
REQ-035 Reset asserted in any state, including mid-move or DONE, SHALL take precedence over every other event that cycle.

Verification
REQ-036 Reset release with BOARD_DIM=8 -> counts 12/12, turn = 1, cell (1,0) = 3'b110, cell (0,0) = 0, cell (0,7) = 3'b100.
REQ-037 Select (1,2) -> after EVAL: slot0 = {1,0,(0,3)}, slot1 = {1,0,(2,3)}, slots 2-3 invalid. Select (2,3) -> (2,3) = 3'b110, (1,2) = 0, turn = 0.
REQ-038 Load red man at (2,2), white at (3,3), white at (5,5), (4,4) and (6,6) empty. Select (2,2) then (4,4) -> white_count decrements and the continuation flag is set. Select (4,4) -> reject. Select (6,6) -> second capture, then SWITCH.
REQ-039 Load red man at (1,6), (0,7) empty. Move to (0,7) -> cell = 3'b111 and the turn ends, with no continuation.
REQ-040 Load the board so white has one piece. Red captures it -> game_over = 1, winner = 1, and a subsequent sel_valid pulses reject.
REQ-041 In WAIT_DEST, select an off-slot location -> reject pulse, state unchanged. Assert rst the next cycle -> full reset values (REQ-032 to REQ-034).
